// File: rtl/rotate_sequencer.sv
//------------------------------------------------------------------------------
// rotate_sequencer
//
// Command-driven shift register sequencer. A command is accepted in IDLE and
// either loads the register, rotates it one bit per cycle for a programmed
// number of steps, or does nothing. Every accepted command ends with a
// one-cycle done pulse, after which the block returns to IDLE.
//
// Optional feature (macro ROTATE_SEQUENCER_ROTR_EN):
//   defined     -> op 11 rotates right, same timing as the left rotate
//   not defined -> op 11 is treated as a NOP
//
// Parameters
//   WIDTH       index width; DATA_WIDTH = 2**WIDTH, SW = 2*DATA_WIDTH,
//               CW = WIDTH+1
//
// Ports
//   clock       sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   block can accept a command this cycle (state IDLE)
//   cmd_op      00 NOP, 01 LOAD, 10 ROTL, 11 ROTR / NOP
//   cmd_data    LOAD value (SW bits)
//   cmd_count   rotate step count (CW bits)
//   busy        command executing (EXEC or DONE)
//   done        one-cycle completion pulse
//   x_out       current shift register contents
//   idx_hi      clog2 of x_out upper half, truncated to WIDTH bits
//   idx_lo      clog2 of x_out lower half, truncated to WIDTH bits
//------------------------------------------------------------------------------
module rotate_sequencer #(
   parameter int WIDTH = 1
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [2*(2**WIDTH)-1:0]   cmd_data,
   input  logic [WIDTH:0]            cmd_count,
   output logic                      busy,
   output logic                      done,
   output logic [2*(2**WIDTH)-1:0]   x_out,
   output logic [WIDTH-1:0]          idx_hi,
   output logic [WIDTH-1:0]          idx_lo
);

   localparam int DATA_WIDTH = 2**WIDTH;
   localparam int SW         = 2*DATA_WIDTH;
   localparam int CW         = WIDTH+1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_ROTL = 2'b10;
   localparam logic [1:0] OP_ROTR = 2'b11;

   logic [1:0]    state;
   logic [SW-1:0] x;
   logic [CW-1:0] cnt;
`ifdef ROTATE_SEQUENCER_ROTR_EN
   logic          dir_right;
`endif

   function automatic logic [SW-1:0] rotl1(input logic [SW-1:0] v);
      return {v[SW-2:0], v[SW-1]};
   endfunction

`ifdef ROTATE_SEQUENCER_ROTR_EN
   function automatic logic [SW-1:0] rotr1(input logic [SW-1:0] v);
      return {v[0], v[SW-1:1]};
   endfunction
`endif

   // Smallest n with 2**n >= v, i.e. bit position of msb(v-1) plus one.
   // v = 0 and v = 1 both map to 0; the result wraps to WIDTH bits.
   function automatic logic [WIDTH-1:0] clog2_trunc(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] vm1;
      logic [WIDTH-1:0]      r;
      vm1 = v - DATA_WIDTH'(1);
      r   = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (vm1[i]) r = WIDTH'(i + 1);
      end
      if (v == '0) r = '0;
      return r;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         x         <= SW'(1);
         cnt       <= '0;
`ifdef ROTATE_SEQUENCER_ROTR_EN
         dir_right <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_LOAD: begin
                        x     <= cmd_data;
                        state <= DONE;
                     end
                     OP_ROTL: begin
                        // A zero count skips EXEC entirely.
                        if (cmd_count != '0) begin
                           cnt   <= cmd_count;
`ifdef ROTATE_SEQUENCER_ROTR_EN
                           dir_right <= 1'b0;
`endif
                           state <= EXEC;
                        end else begin
                           state <= DONE;
                        end
                     end
                     OP_ROTR: begin
`ifdef ROTATE_SEQUENCER_ROTR_EN
                        if (cmd_count != '0) begin
                           cnt       <= cmd_count;
                           dir_right <= 1'b1;
                           state     <= EXEC;
                        end else begin
                           state <= DONE;
                        end
`else
                        state <= DONE;
`endif
                     end
                     default: state <= DONE;
                  endcase
               end
            end
            EXEC: begin
`ifdef ROTATE_SEQUENCER_ROTR_EN
               x <= dir_right ? rotr1(x) : rotl1(x);
`else
               x <= rotl1(x);
`endif
               cnt <= cnt - CW'(1);
               // cnt still holds the steps remaining including this one.
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = ~cmd_ready;
   assign done      = (state == DONE);
   assign x_out     = x;
   assign idx_hi    = clog2_trunc(x[SW-1:DATA_WIDTH]);
   assign idx_lo    = clog2_trunc(x[DATA_WIDTH-1:0]);

endmodule
